alu_result_fifo: RTL and testbench

Downstream stage of the registered ALU/compare stage (opc/a/b in, 8-bit c out one clock later). Tracks which cycles carried a real operation, captures each valid result with its opcode tag into a small synchronous FIFO, and presents results to a consumer over a valid/ready handshake. Exports a credit signal so the upstream issuer never launches an operation whose result has no slot.

---
 rtl/alu_result_fifo_pkg.sv | 19 +
 rtl/alu_result_fifo_if.sv | 29 ++
 rtl/alu_result_fifo_sync_fifo.sv | 54 +++++
 rtl/alu_result_fifo.sv | 72 +++++++
 tb/tb_alu_result_fifo.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_fifo_pkg.sv
// Shared widths, opcode constants and the entry layout for the ALU result FIFO.
// Opcodes at or above OPC_CMP_MIN belong to the compare group.
package alu_result_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OPC_W  = 3;
    localparam int DEF_DEPTH  = 4;

    localparam logic [DEF_OPC_W-1:0] OPC_ADD     = 3'd0;
    localparam logic [DEF_OPC_W-1:0] OPC_SUB     = 3'd1;
    localparam logic [DEF_OPC_W-1:0] OPC_MUL     = 3'd2;
    localparam logic [DEF_OPC_W-1:0] OPC_CMP_MIN = 3'd3;

    typedef struct packed {
        logic [DEF_OPC_W-1:0]  opc;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Issue-credit and result valid/ready bundle between issuer/consumer and the result FIFO.
// The master side is the issuer/consumer; the slave side is the FIFO block.
interface alu_result_fifo_if
    import alu_result_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPC_W  = DEF_OPC_W
);

    logic              issue_valid;
    logic [OPC_W-1:0]  issue_opc;
    logic              issue_ready;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [OPC_W-1:0]  res_opc;
    logic              res_is_cmp;

    modport master (
        output issue_valid, issue_opc, res_ready,
        input  issue_ready, res_valid, res_data, res_opc, res_is_cmp
    );

    modport slave (
        input  issue_valid, issue_opc, res_ready,
        output issue_ready, res_valid, res_data, res_opc, res_is_cmp
    );

endinterface

// File: rtl/alu_result_fifo_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_pushData,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_headData,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);
    assign o_count  = r_count;

    // An empty FIFO presents zeros rather than stale storage contents.
    assign o_headData = o_empty ? '0 : r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + PTR_W'(w_doPush);
            r_rdPtr <= r_rdPtr + PTR_W'(w_doPop);
            r_count <= r_count + (PTR_W+1)'(w_doPush) - (PTR_W+1)'(w_doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Captures tagged ALU/compare results one clock after issue and queues them for a consumer.
// Issue credit counts stored entries plus the result still in flight.
module alu_result_fifo
    import alu_result_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPC_W  = DEF_OPC_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_result_fifo_if.slave       bus,
    input  logic [DATA_W-1:0]      c_in,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int ENT_W = OPC_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              r_pendV;
    logic [OPC_W-1:0]  r_pendOpc;
    logic              r_overflow;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_credit;

    // Credit is built from registered state only, so issue_ready never depends on issue_valid.
    assign w_credit        = {1'b0, w_count} + (CNT_W+1)'(r_pendV);
    assign bus.issue_ready = (w_credit < (CNT_W+1)'(DEPTH));

    assign bus.res_valid              = ~w_empty;
    assign w_pop                      = bus.res_valid & bus.res_ready;
    assign {bus.res_opc, bus.res_data} = w_head;
    assign bus.res_is_cmp             = (bus.res_opc >= OPC_W'(OPC_CMP_MIN));

    assign count    = w_count;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendV    <= 1'b0;
            r_pendOpc  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pendV   <= bus.issue_valid & bus.issue_ready;
            r_pendOpc <= bus.issue_opc;
            if (r_pendV && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_pendV),
        .i_pushData ({r_pendOpc, c_in}),
        .i_pop      (w_pop),
        .o_headData (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: each scenario task drives vectors and checks hand-computed results.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_alu_result_fifo;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic [2:0] opc;
        logic       cmp;
        logic [2:0] cnt;
        logic       ovf;
        logic       rdy;
    } status_t;

    logic       clk;
    logic       rst;
    logic [7:0] cIn;
    logic [2:0] count;
    logic       overflow;
    int         checksTotal;
    int         checksPassed;

    alu_result_fifo_if #(.DATA_W(8), .OPC_W(3)) bus ();

    alu_result_fifo #(
        .DATA_W (8),
        .OPC_W  (3),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .c_in     (cIn),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic status_t sample();
        status_t s;
        s.valid = bus.res_valid;
        s.data  = bus.res_data;
        s.opc   = bus.res_opc;
        s.cmp   = bus.res_is_cmp;
        s.cnt   = count;
        s.ovf   = overflow;
        s.rdy   = bus.issue_ready;
        return s;
    endfunction

    function automatic status_t mk(input logic v, input logic [7:0] d, input logic [2:0] o,
                                   input logic c, input logic [2:0] n, input logic ov,
                                   input logic r);
        status_t s;
        s.valid = v;
        s.data  = d;
        s.opc   = o;
        s.cmp   = c;
        s.cnt   = n;
        s.ovf   = ov;
        s.rdy   = r;
        return s;
    endfunction

    // Pretend an in-flight result exists for exactly one rising edge, as a credit-ignoring issuer would.
    task automatic injectPending();
        force dut.r_pendV = 1'b1;
        @(posedge clk);
        #1;
        force dut.r_pendV = 1'b0;
        @(negedge clk);
        release dut.r_pendV;
    endtask

    task automatic test_reset();
        status_t got, exp;
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_opc   = 3'd0;
        bus.res_ready   = 1'b0;
        cIn = 8'hEE;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        got = sample();
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL reset_state: got %p required %p", got, exp);
        else checksPassed++;
    endtask

    task automatic test_single();
        status_t got, exp;
        bus.issue_valid = 1'b1;
        bus.issue_opc   = 3'd1;
        bus.res_ready   = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.issue_opc   = 3'd0;
        cIn = 8'h05;
        got = sample();
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL single_one_clock: got %p required %p", got, exp);
        else checksPassed++;
        @(negedge clk);
        cIn = 8'hEE;
        got = sample();
        exp = mk(1'b1, 8'h05, 3'd1, 1'b0, 3'd1, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL single_head: got %p required %p", got, exp);
        else checksPassed++;
        @(negedge clk);
        bus.res_ready = 1'b0;
        got = sample();
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL single_popped: got %p required %p", got, exp);
        else checksPassed++;
    endtask

    task automatic test_back_to_back();
        status_t got, exp;
        bus.res_ready   = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_opc   = 3'd3;
        @(negedge clk);
        cIn = 8'h01;
        bus.issue_opc = 3'd4;
        @(negedge clk);
        cIn = 8'h00;
        bus.issue_opc = 3'd0;
        @(negedge clk);
        cIn = 8'h0C;
        bus.issue_opc = 3'd7;
        got = sample();
        exp = mk(1'b1, 8'h01, 3'd3, 1'b1, 3'd2, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL b2b_credit_left: got %p required %p", got, exp);
        else checksPassed++;
        @(negedge clk);
        cIn = 8'h01;
        bus.issue_valid = 1'b0;
        got = sample();
        exp = mk(1'b1, 8'h01, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL b2b_credit_drop: got %p required %p", got, exp);
        else checksPassed++;
        @(negedge clk);
        cIn = 8'hEE;
        got = sample();
        exp = mk(1'b1, 8'h01, 3'd3, 1'b1, 3'd4, 1'b0, 1'b0);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL b2b_full: got %p required %p", got, exp);
        else checksPassed++;
    endtask

    task automatic test_full_push_pop();
        status_t got, exp;
        logic [7:0] dExp [4] = '{8'h00, 8'h0C, 8'h01, 8'hA5};
        logic [2:0] oExp [4] = '{3'd4, 3'd0, 3'd7, 3'd7};
        logic       cExp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bus.res_ready = 1'b1;
        cIn = 8'hA5;
        injectPending();
        cIn = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            got = sample();
            exp = mk(1'b1, dExp[i], oExp[i], cExp[i], 3'(4 - i), 1'b0, (i > 0));
            checksTotal++;
            if (got !== exp) $display("[TB] FAIL fullpp_drain%0d: got %p required %p", i, got, exp);
            else checksPassed++;
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        got = sample();
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL fullpp_empty: got %p required %p", got, exp);
        else checksPassed++;
    endtask

    task automatic test_ignored_issue();
        status_t got, exp;
        bus.res_ready   = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_opc   = 3'd2;
        @(negedge clk);
        cIn = 8'h10;
        @(negedge clk);
        cIn = 8'h20;
        @(negedge clk);
        cIn = 8'h30;
        @(negedge clk);
        cIn = 8'h40;
        @(negedge clk);
        cIn = 8'h50;
        for (int i = 0; i < 3; i++) begin
            got = sample();
            exp = mk(1'b1, 8'h10, 3'd2, 1'b0, 3'd4, 1'b0, 1'b0);
            checksTotal++;
            if (got !== exp) $display("[TB] FAIL ignored_issue%0d: got %p required %p", i, got, exp);
            else checksPassed++;
            @(negedge clk);
            cIn = 8'h60;
        end
        bus.issue_valid = 1'b0;
    endtask

    task automatic test_overflow();
        status_t got, exp;
        logic [7:0] dExp [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        bus.res_ready = 1'b0;
        cIn = 8'h77;
        injectPending();
        cIn = 8'hEE;
        got = sample();
        exp = mk(1'b1, 8'h10, 3'd2, 1'b0, 3'd4, 1'b1, 1'b0);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL overflow_set: got %p required %p", got, exp);
        else checksPassed++;
        repeat (2) @(negedge clk);
        got = sample();
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL overflow_held: got %p required %p", got, exp);
        else checksPassed++;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = sample();
            exp = mk(1'b1, dExp[i], 3'd2, 1'b0, 3'(4 - i), 1'b1, (i > 0));
            checksTotal++;
            if (got !== exp) $display("[TB] FAIL overflow_drain%0d: got %p required %p", i, got, exp);
            else checksPassed++;
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        got = sample();
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL overflow_sticky_empty: got %p required %p", got, exp);
        else checksPassed++;
    endtask

    task automatic test_reset_inflight();
        status_t got, exp;
        bus.res_ready   = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_opc   = 3'd5;
        @(negedge clk);
        cIn = 8'h11;
        bus.issue_opc = 3'd6;
        @(negedge clk);
        cIn = 8'h22;
        bus.issue_opc = 3'd1;
        @(negedge clk);
        cIn = 8'h33;
        bus.issue_valid = 1'b0;
        got = sample();
        exp = mk(1'b1, 8'h11, 3'd5, 1'b1, 3'd2, 1'b1, 1'b1);
        checksTotal++;
        if (got !== exp) $display("[TB] FAIL rst_pre: got %p required %p", got, exp);
        else checksPassed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cIn = 8'hEE;
        exp = mk(1'b0, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            got = sample();
            checksTotal++;
            if (got !== exp) $display("[TB] FAIL rst_cleared%0d: got %p required %p", i, got, exp);
            else checksPassed++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_push_pop();
        test_ignored_issue();
        test_overflow();
        test_reset_inflight();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
